// File: rtl/pia_pkg.sv
// rtl/pia_pkg.sv - shared constants and types for the 6821-style PIA channels
package pia_pkg;

  localparam int CR_C1_EN   = 0;
  localparam int CR_C1_EDGE = 1;
  localparam int CR_DDR_SEL = 2;
  localparam int CR_C2_CTL  = 3;
  localparam int CR_C2_EDGE = 4;
  localparam int CR_C2_OUT  = 5;
  localparam int CR_IRQ2    = 6;
  localparam int CR_IRQ1    = 7;

  localparam logic [2:0] C2_HANDSHAKE = 3'b100;
  localparam logic [2:0] C2_PULSE     = 3'b101;
  localparam logic [1:0] C2_MANUAL    = 2'b11;

  typedef enum logic [1:0] {
    C2S_IDLE,
    C2S_WAIT,
    C2S_PULSE
  } c2_state_e;

endpackage

// File: rtl/pia_port.sv
// rtl/pia_port.sv - one PIA channel: registers, C1/C2 edge detect, C2 strobe FSM, flags
module pia_port #(
  parameter int PORT_W = 8,
  parameter bit IS_B   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              sel,
  input  logic              we,
  input  logic              rs,
  input  logic [7:0]        din,
  input  logic [PORT_W-1:0] pin,
  input  logic              c1_in,
  input  logic              c2_in,
  output logic [7:0]        rdata,
  output logic [PORT_W-1:0] pout,
  output logic [PORT_W-1:0] pddr,
  output logic              c2_out,
  output logic              c2_oe,
  output logic              irq
);
  import pia_pkg::*;

  logic [5:0]        cr;
  logic [PORT_W-1:0] ora;
  logic [PORT_W-1:0] ddr;
  logic              irq1;
  logic              irq2;
  logic              c1_s1, c1_s2, c1_prev;
  logic              c2_s1, c2_s2, c2_prev;
  c2_state_e         state, state_n;

  logic access, rd_data, wr_data, wr_ddr, wr_cr, strobe;
  logic c1_edge, c2_edge;
  logic unused_din;

  assign unused_din = ^din[7:6];

  assign access  = sel & ce;
  assign rd_data = access & ~we & ~rs & cr[CR_DDR_SEL];
  assign wr_data = access & we & ~rs & cr[CR_DDR_SEL];
  assign wr_ddr  = access & we & ~rs & ~cr[CR_DDR_SEL];
  assign wr_cr   = access & we & rs;
  // A side strobes on data reads, B side on data writes
  assign strobe  = IS_B ? wr_data : rd_data;

  assign c1_edge = (c1_s2 != c1_prev) & (c1_s2 == cr[CR_C1_EDGE]);
  assign c2_edge = ~cr[CR_C2_OUT] & (c2_s2 != c2_prev) & (c2_s2 == cr[CR_C2_EDGE]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cr      <= '0;
      ora     <= '0;
      ddr     <= '0;
      irq1    <= 1'b0;
      irq2    <= 1'b0;
      // preload with the live pins so leaving reset is not seen as an edge
      c1_s1   <= c1_in;
      c1_s2   <= c1_in;
      c1_prev <= c1_in;
      c2_s1   <= c2_in;
      c2_s2   <= c2_in;
      c2_prev <= c2_in;
    end else if (ce) begin
      c1_s1   <= c1_in;
      c1_s2   <= c1_s1;
      c1_prev <= c1_s2;
      c2_s1   <= c2_in;
      c2_s2   <= c2_s1;
      c2_prev <= c2_s2;
      if (wr_cr)   cr  <= din[5:0];
      if (wr_ddr)  ddr <= din[PORT_W-1:0];
      if (wr_data) ora <= din[PORT_W-1:0];
      if (c1_edge)      irq1 <= 1'b1;
      else if (rd_data) irq1 <= 1'b0;
      if (c2_edge)      irq2 <= 1'b1;
      else if (rd_data || (wr_cr && din[CR_C2_OUT])) irq2 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)  state <= C2S_IDLE;
    else if (ce) state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cr[5:3] == C2_HANDSHAKE) begin
      if (strobe)       state_n = C2S_WAIT;
      else if (c1_edge) state_n = C2S_IDLE;
    end else if (cr[5:3] == C2_PULSE) begin
      state_n = strobe ? C2S_PULSE : C2S_IDLE;
    end else begin
      state_n = C2S_IDLE;
    end
  end

  always_comb begin
    rdata = '0;
    if (rs) begin
      rdata[CR_IRQ1]      = irq1;
      rdata[CR_IRQ2]      = irq2;
      rdata[CR_C2_OUT:0]  = cr;
    end else if (cr[CR_DDR_SEL]) begin
      rdata[PORT_W-1:0] = (ora & ddr) | (pin & ~ddr);
    end else begin
      rdata[PORT_W-1:0] = ddr;
    end
  end

  assign pout   = ora;
  assign pddr   = ddr;
  assign c2_oe  = cr[CR_C2_OUT];
  assign c2_out = ~cr[CR_C2_OUT] ? 1'b1 :
                  (cr[5:4] == C2_MANUAL) ? cr[CR_C2_CTL] : (state == C2S_IDLE);
  assign irq    = (irq1 & cr[CR_C1_EN]) | (irq2 & cr[CR_C2_CTL] & ~cr[CR_C2_OUT]);

endmodule

// File: rtl/pia6821_multi.sv
// rtl/pia6821_multi.sv - NUM_PORTS-channel 6821-style PIA with shared register bus
module pia6821_multi #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        cs,
  input  logic                        we,
  input  logic [$clog2(NUM_PORTS):0]  addr,
  input  logic [7:0]                  din,
  output logic [7:0]                  dout,
  input  logic [NUM_PORTS*PORT_W-1:0] port_in,
  output logic [NUM_PORTS*PORT_W-1:0] port_out,
  output logic [NUM_PORTS*PORT_W-1:0] port_ddr,
  input  logic [NUM_PORTS-1:0]        c1_in,
  input  logic [NUM_PORTS-1:0]        c2_in,
  output logic [NUM_PORTS-1:0]        c2_out,
  output logic [NUM_PORTS-1:0]        c2_oe,
  output logic [NUM_PORTS-1:0]        irq,
  output logic                        irq_any
);
  import pia_pkg::*;

  localparam int AW = $clog2(NUM_PORTS);

  logic [AW-1:0] ch;
  logic [7:0]    rdata [NUM_PORTS];

  assign ch = addr[AW:1];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    pia_port #(
      .PORT_W (PORT_W),
      .IS_B   ((k % 2) == 1)
    ) u_port (
      .clk    (clk),
      .reset  (reset),
      .ce     (ce),
      .sel    (cs && (ch == AW'(k))),
      .we     (we),
      .rs     (addr[0]),
      .din    (din),
      .pin    (port_in[k*PORT_W +: PORT_W]),
      .c1_in  (c1_in[k]),
      .c2_in  (c2_in[k]),
      .rdata  (rdata[k]),
      .pout   (port_out[k*PORT_W +: PORT_W]),
      .pddr   (port_ddr[k*PORT_W +: PORT_W]),
      .c2_out (c2_out[k]),
      .c2_oe  (c2_oe[k]),
      .irq    (irq[k])
    );
  end

  assign dout    = cs ? rdata[ch] : 8'hFF;
  assign irq_any = |irq;

endmodule

// File: tb/tb_pia6821_multi.sv
// tb/tb_pia6821_multi.sv - self-checking bench for pia6821_multi (2 channels, 8-bit ports)
module tb_pia6821_multi;

  logic        clk = 1'b0;
  logic        reset, ce, cs, we;
  logic [1:0]  addr;
  logic [7:0]  din, dout;
  logic [15:0] port_in, port_out, port_ddr;
  logic [1:0]  c1_in, c2_in, c2_out, c2_oe, irq;
  logic        irq_any;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pia6821_multi #(.NUM_PORTS(2), .PORT_W(8)) dut (
    .clk(clk), .reset(reset), .ce(ce), .cs(cs), .we(we), .addr(addr),
    .din(din), .dout(dout), .port_in(port_in), .port_out(port_out),
    .port_ddr(port_ddr), .c1_in(c1_in), .c2_in(c2_in), .c2_out(c2_out),
    .c2_oe(c2_oe), .irq(irq), .irq_any(irq_any)
  );

  typedef struct {
    bit         we;
    int         ch;
    bit         rs;
    logic [7:0] d;
    logic [7:0] pin;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[$];

  // reference model state
  logic [5:0] m_cr  [2];
  logic [7:0] m_ora [2];
  logic [7:0] m_ddr [2];
  bit         m_f1  [2];
  bit         m_f2  [2];
  logic [3:0] h1    [2];
  logic [3:0] h2    [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    ce = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0; cs = 1'b0; we = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input bit rs, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = {ch[0], rs}; din = d;
    tick();
  endtask

  task automatic rd_chk(input string nm, input int ch, input bit rs, input logic [7:0] exp);
    cs = 1'b1; we = 1'b0; addr = {ch[0], rs};
    #1;
    chk(nm, 64'(dout), 64'(exp));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  function automatic void add_vec(input bit w, input int c, input bit r,
                                  input logic [7:0] d, input logic [7:0] p, input logic [7:0] e);
    vec_t x;
    x.we = w; x.ch = c; x.rs = r; x.d = d; x.pin = p; x.exp = e;
    vt.push_back(x);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cr[k] = '0; m_ora[k] = '0; m_ddr[k] = '0; m_f1[k] = 1'b0; m_f2[k] = 1'b0;
      h1[k] = {4{c1_in[k]}};
      h2[k] = {4{c2_in[k]}};
    end
  endfunction

  function automatic logic [7:0] model_read(input int ch, input bit rs);
    logic [7:0] p;
    p = port_in[ch*8 +: 8];
    if (rs) return {m_f1[ch], m_f2[ch], m_cr[ch]};
    if (m_cr[ch][2]) return (m_ora[ch] & m_ddr[ch]) | (p & ~m_ddr[ch]);
    return m_ddr[ch];
  endfunction

  // One ce tick: a pin transition between the samples taken 3 and 2 ticks ago
  // becomes a flag on this tick, matching the stated 3-cycle edge latency.
  function automatic void model_tick(input bit acc, input bit w, input int ch,
                                     input bit rs, input logic [7:0] d);
    for (int k = 0; k < 2; k++) begin
      bit e1, e2, a, rdd;
      h1[k] = {h1[k][2:0], c1_in[k]};
      h2[k] = {h2[k][2:0], c2_in[k]};
      e1  = (h1[k][3] != h1[k][2]) && (h1[k][2] == m_cr[k][1]);
      e2  = !m_cr[k][5] && (h2[k][3] != h2[k][2]) && (h2[k][2] == m_cr[k][4]);
      a   = acc && (ch == k);
      rdd = a && !w && !rs && m_cr[k][2];
      m_f1[k] = e1 || (m_f1[k] && !rdd);
      m_f2[k] = e2 || (m_f2[k] && !(rdd || (a && w && rs && d[5])));
      if (a && w) begin
        if (rs)               m_cr[k]  = d[5:0];
        else if (m_cr[k][2])  m_ora[k] = d;
        else                  m_ddr[k] = d;
      end
    end
  endfunction

  function automatic logic [63:0] model_outputs();
    logic [1:0] i, c2o, oe;
    for (int k = 0; k < 2; k++) begin
      i[k]   = (m_f1[k] & m_cr[k][0]) | (m_f2[k] & m_cr[k][3] & ~m_cr[k][5]);
      oe[k]  = m_cr[k][5];
      c2o[k] = (m_cr[k][5:4] == 2'b11) ? m_cr[k][3] : 1'b1;
    end
    return 64'({m_ora[1], m_ora[0], m_ddr[1], m_ddr[0], i, c2o, oe, |i});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; ce = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    port_in = '0; c1_in = 2'b00; c2_in = 2'b11;
    idle();
    do_reset();

    chk("rst_c2_out",   64'(c2_out),   64'(2'b11));
    chk("rst_c2_oe",    64'(c2_oe),    64'(2'b00));
    chk("rst_irq",      64'(irq),      64'(2'b00));
    chk("rst_irq_any",  64'(irq_any),  64'(1'b0));
    chk("rst_port_out", 64'(port_out), 64'(16'h0000));
    chk("rst_port_ddr", 64'(port_ddr), 64'(16'h0000));
    #1;
    chk("cs_low_dout",  64'(dout),     64'(8'hFF));

    add_vec(1'b0, 0, 1'b1, 8'h00, 8'h00, 8'h00);
    add_vec(1'b0, 0, 1'b0, 8'h00, 8'h00, 8'h00);
    add_vec(1'b0, 1, 1'b1, 8'h00, 8'h00, 8'h00);
    add_vec(1'b0, 1, 1'b0, 8'h00, 8'h00, 8'h00);
    add_vec(1'b1, 0, 1'b0, 8'hF0, 8'h00, 8'h00);
    add_vec(1'b1, 0, 1'b1, 8'h04, 8'h00, 8'h00);
    add_vec(1'b1, 0, 1'b0, 8'hA5, 8'h00, 8'h00);
    add_vec(1'b0, 0, 1'b0, 8'h00, 8'h3C, 8'hAC);
    add_vec(1'b1, 0, 1'b1, 8'hC4, 8'h00, 8'h00);
    add_vec(1'b0, 0, 1'b1, 8'h00, 8'h3C, 8'h04);
    add_vec(1'b1, 0, 1'b1, 8'h00, 8'h00, 8'h00);
    add_vec(1'b0, 0, 1'b0, 8'h00, 8'h3C, 8'hF0);
    add_vec(1'b1, 1, 1'b0, 8'h0F, 8'h00, 8'h00);
    add_vec(1'b1, 1, 1'b1, 8'h04, 8'h00, 8'h00);
    add_vec(1'b1, 1, 1'b0, 8'h5A, 8'h00, 8'h00);
    add_vec(1'b0, 1, 1'b0, 8'h00, 8'hC3, 8'hCA);
    add_vec(1'b0, 0, 1'b0, 8'h00, 8'h3C, 8'hF0);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].we) begin
        wr(vt[i].ch, vt[i].rs, vt[i].d);
      end else begin
        port_in[vt[i].ch*8 +: 8] = vt[i].pin;
        rd_chk($sformatf("vec%0d_dout", i), vt[i].ch, vt[i].rs, vt[i].exp);
      end
    end
    chk("vec_port_out", 64'(port_out), 64'(16'h5AA5));
    chk("vec_port_ddr", 64'(port_ddr), 64'(16'h0FF0));

    // C1 rising edge on channel 1
    wr(1, 1'b1, 8'h07);
    c1_in[1] = 1'b1;
    tick(); tick();
    chk("c1_irq_early", 64'(irq), 64'(2'b00));
    tick();
    chk("c1_irq_set",   64'(irq), 64'(2'b10));
    chk("c1_irq_any",   64'(irq_any), 64'(1'b1));
    rd_chk("c1_cr1_flag", 1, 1'b1, 8'h87);
    rd_chk("c1_data_rd",  1, 1'b0, 8'hCA);
    chk("c1_irq_clr",   64'(irq), 64'(2'b00));
    c1_in[1] = 1'b0;
    repeat (4) tick();
    rd_chk("c1_fall_ignored", 1, 1'b1, 8'h07);
    wr(1, 1'b1, 8'h05);
    c1_in[1] = 1'b1;
    repeat (4) tick();
    rd_chk("c1_rise_ignored", 1, 1'b1, 8'h05);
    chk("c1_rise_noirq", 64'(irq), 64'(2'b00));

    // handshake on channel 0 (A side, falling C1 edge releases)
    wr(0, 1'b1, 8'h24);
    chk("hs_oe",        64'(c2_oe), 64'(2'b01));
    chk("hs_idle_high", 64'(c2_out[0]), 64'(1'b1));
    rd_chk("hs_strobe_rd", 0, 1'b0, 8'hAC);
    chk("hs_low",       64'(c2_out[0]), 64'(1'b0));
    c1_in[0] = 1'b1;
    repeat (4) tick();
    chk("hs_rise_held", 64'(c2_out[0]), 64'(1'b0));
    c1_in[0] = 1'b0;
    tick(); tick();
    chk("hs_not_yet",   64'(c2_out[0]), 64'(1'b0));
    tick();
    chk("hs_release",   64'(c2_out[0]), 64'(1'b1));

    // pulse on channel 1 (B side, strobed by data write)
    wr(1, 1'b1, 8'h2C);
    chk("pl_oe",        64'(c2_oe[1]), 64'(1'b1));
    chk("pl_idle_high", 64'(c2_out[1]), 64'(1'b1));
    wr(1, 1'b0, 8'h33);
    chk("pl_low",       64'(c2_out[1]), 64'(1'b0));
    idle(); idle();
    chk("pl_hold_ce0",  64'(c2_out[1]), 64'(1'b0));
    tick();
    chk("pl_end",       64'(c2_out[1]), 64'(1'b1));
    rd_chk("pl_data_rd", 1, 1'b0, 8'hC3);
    chk("pl_rd_nopulse", 64'(c2_out[1]), 64'(1'b1));
    tick();
    chk("pl_rd_nopulse2", 64'(c2_out[1]), 64'(1'b1));

    // strobe and active C1 edge land on the same ce edge
    wr(0, 1'b1, 8'h25);
    c1_in[0] = 1'b1; tick();
    c1_in[0] = 1'b0; tick();
    tick();
    rd_chk("sim_data_rd", 0, 1'b0, 8'hAC);
    chk("sim_strobe_wins", 64'(c2_out[0]), 64'(1'b0));
    chk("sim_set_wins",    64'(irq[0]),    64'(1'b1));
    rd_chk("sim_cr0", 0, 1'b1, 8'hA5);

    // reset mid-handshake with a colliding write and a changed C1 pin
    c1_in[1] = 1'b0;
    cs = 1'b1; we = 1'b1; addr = 2'b01; din = 8'hFF;
    do_reset();
    chk("mrst_c2_out",   64'(c2_out),   64'(2'b11));
    chk("mrst_c2_oe",    64'(c2_oe),    64'(2'b00));
    chk("mrst_irq",      64'(irq),      64'(2'b00));
    chk("mrst_port_out", 64'(port_out), 64'(16'h0000));
    chk("mrst_port_ddr", 64'(port_ddr), 64'(16'h0000));
    repeat (4) tick();
    rd_chk("mrst_cr0", 0, 1'b1, 8'h00);
    rd_chk("mrst_cr1", 1, 1'b1, 8'h00);

    // randomized traffic against the reference model
    c1_in = 2'($urandom);
    c2_in = 2'($urandom);
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      int         ch, op;
      bit         rs;
      logic [7:0] d;
      port_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) c1_in = 2'($urandom);
      if ($urandom_range(0, 3) == 0) c2_in = 2'($urandom);
      ch = $urandom_range(0, 1);
      op = $urandom_range(0, 5);
      d  = 8'($urandom);
      if (op == 4 && d[5]) d[4] = 1'b1;
      rs   = (op == 2) || (op == 4);
      cs   = (op >= 1) && (op <= 4);
      we   = (op >= 3) && (op <= 4);
      addr = {ch[0], rs};
      din  = d;
      #1;
      if (op == 1 || op == 2) chk("rand_dout", 64'(dout), 64'(model_read(ch, rs)));
      model_tick(cs, we, ch, rs, d);
      tick();
      chk("rand_outputs", {25'd0, port_out, port_ddr, irq, c2_out, c2_oe, irq_any},
          model_outputs());
      if ($urandom_range(0, 3) == 0) idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
